// File: rtl/clock_step_controller.sv
// Clock-enable generator with run/halt/single-step sequencing; tick_en is a registered pulse every div_reg+1 cycles.
// First tick lands div_reg+1 cycles after entering RUNNING/STEPPING; halts take effect on the sampling edge.
module clock_step_controller #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 div_load,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 cpu_halt,
  output logic                 tick_en,
  output logic                 ext_clk,
  output logic                 step_done,
  output logic [1:0]           state,
  output logic [15:0]          tick_count
);

  typedef enum logic [1:0] {
    HALTED   = 2'b00,
    RUNNING  = 2'b01,
    STEPPING = 2'b10
  } state_t;

  state_t               cur_state;
  state_t               nxt_state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] cnt_nxt;
  logic [DIV_WIDTH-1:0] div_reg;
  logic                 tick_nxt;
  logic                 done_nxt;
  logic                 terminal;

  // Compare against the divisor in force before any coincident div_load.
  assign terminal = (cnt == div_reg);
  assign state    = cur_state;

  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = '0;
    tick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (cur_state)
      HALTED: begin
        if (run && !cpu_halt) begin
          nxt_state = RUNNING;
        end else if (step_req) begin
          nxt_state = STEPPING;
        end
      end
      RUNNING: begin
        if (halt_req || cpu_halt) begin
          nxt_state = HALTED;
        end else if (terminal) begin
          tick_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STEPPING: begin
        if (halt_req) begin
          nxt_state = HALTED;
        end else if (terminal) begin
          nxt_state = HALTED;
          tick_nxt  = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: nxt_state = HALTED;
    endcase
    if (div_load) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state  <= HALTED;
      cnt        <= '0;
      div_reg    <= DIV_WIDTH'(DEFAULT_DIV);
      tick_en    <= 1'b0;
      ext_clk    <= 1'b0;
      step_done  <= 1'b0;
      tick_count <= 16'd0;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_nxt;
      tick_en   <= tick_nxt;
      step_done <= done_nxt;
      if (div_load) begin
        div_reg <= div_value;
      end
      if (tick_nxt) begin
        ext_clk    <= ~ext_clk;
        tick_count <= tick_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed bench: stimulus queues expected ticks, a monitor pops and checks them as tick_en fires.
module tb_clock_step_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  div_value;
  logic        div_load;
  logic        run;
  logic        halt_req;
  logic        step_req;
  logic        cpu_halt;
  logic        tick_en;
  logic        ext_clk;
  logic        step_done;
  logic [1:0]  state;
  logic [15:0] tick_count;

  clock_step_controller #(.DIV_WIDTH(8), .DEFAULT_DIV(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_value  (div_value),
    .div_load   (div_load),
    .run        (run),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .cpu_halt   (cpu_halt),
    .tick_en    (tick_en),
    .ext_clk    (ext_clk),
    .step_done  (step_done),
    .state      (state),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic        ext;
    logic [15:0] tc;
    logic        sd;
    logic [1:0]  st;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic        exp_ext;
  logic [15:0] exp_tc;
  int          e;
  int          n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_tick(input int c, input logic sd, input logic [1:0] st);
    exp_t x;
    exp_ext = ~exp_ext;
    exp_tc  = exp_tc + 16'd1;
    x.c   = c;
    x.ext = exp_ext;
    x.tc  = exp_tc;
    x.sd  = sd;
    x.st  = st;
    q.push_back(x);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) nxt();
  endtask

  task automatic load_div(input logic [7:0] d);
    div_value = d;
    div_load  = 1'b1;
    nxt();
    div_load  = 1'b0;
  endtask

  // Monitor: every tick_en pulse must match the head of the expected queue.
  always @(posedge clk) begin
    #1;
    if (tick_en === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_tick: tick_en=1 at cycle %0d, none expected", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("tick_cycle", cyc, mon_e.c);
        chk("tick_ext_clk", ext_clk, mon_e.ext);
        chk("tick_count", tick_count, mon_e.tc);
        chk("tick_step_done", step_done, mon_e.sd);
        chk("tick_state", state, mon_e.st);
      end
    end else begin
      if (step_done === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL stray_step_done: step_done=1 without tick at cycle %0d", cyc);
      end
      if (q.size() != 0 && q[0].c <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_tick: expected tick at cycle %0d, tick_en=0", q[0].c);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; div_value = '0; div_load = 1'b0; run = 1'b0;
    halt_req = 1'b0; step_req = 1'b0; cpu_halt = 1'b0;
    exp_ext = 1'b0; exp_tc = 16'd0;

    // 1: reset state
    repeat (5) nxt();
    chk("reset_state", state, 2'b00);
    chk("reset_tick_en", tick_en, 1'b0);
    chk("reset_ext_clk", ext_clk, 1'b0);
    chk("reset_tick_count", tick_count, 16'd0);
    chk("reset_step_done", step_done, 1'b0);
    reset = 1'b0;
    nxt();

    // 2: default divisor 3, free run for 20 cycles
    run = 1'b1;
    e = cyc + 1;
    for (int k = 1; k <= 5; k++) push_tick(e + 4 * k, 1'b0, 2'b01);
    nxt();
    chk("run_entry_state", state, 2'b01);
    wait_until(e + 20);
    halt_req = 1'b1; run = 1'b0;
    nxt();
    halt_req = 1'b0;
    chk("run_halted_state", state, 2'b00);
    chk("run_count_5", tick_count, 16'd5);

    // 3: divisor 0 loaded while halted gives a tick every cycle
    load_div(8'd0);
    chk("load_keeps_halted", state, 2'b00);
    run = 1'b1;
    e = cyc + 1;
    for (int k = 1; k <= 6; k++) push_tick(e + k, 1'b0, 2'b01);
    wait_until(e + 6);
    halt_req = 1'b1; run = 1'b0;
    nxt();
    halt_req = 1'b0;
    chk("div0_halted_state", state, 2'b00);
    chk("div0_tick_en_off", tick_en, 1'b0);
    chk("div0_count", tick_count, 16'd11);

    // 4: single step with divisor 2; a second step request mid-step is ignored
    load_div(8'd2);
    step_req = 1'b1;
    e = cyc + 1;
    push_tick(e + 3, 1'b1, 2'b00);
    nxt();
    step_req = 1'b0;
    chk("step_state_c0", state, 2'b10);
    nxt();
    step_req = 1'b1;
    chk("step_state_c1", state, 2'b10);
    nxt();
    step_req = 1'b0;
    chk("step_state_c2", state, 2'b10);
    nxt();
    chk("step_done_state", state, 2'b00);
    nxt();
    chk("step_done_pulse_end", step_done, 1'b0);
    repeat (4) nxt();
    chk("step_stays_halted", state, 2'b00);
    chk("step_count", tick_count, 16'd12);

    // 5a: halt_req exactly at terminal count suppresses the tick
    load_div(8'd3);
    run = 1'b1;
    e = cyc + 1;
    wait_until(e + 3);
    halt_req = 1'b1; run = 1'b0;
    nxt();
    halt_req = 1'b0;
    chk("halt_tc_state", state, 2'b00);
    chk("halt_tc_no_tick", tick_en, 1'b0);
    repeat (3) nxt();

    // 5b: cpu_halt at terminal count, run held: stays halted, step still works
    run = 1'b1;
    e = cyc + 1;
    wait_until(e + 3);
    cpu_halt = 1'b1;
    nxt();
    chk("cpu_halt_state", state, 2'b00);
    chk("cpu_halt_no_tick", tick_en, 1'b0);
    for (int k = 0; k < 6; k++) begin
      nxt();
      chk("cpu_halt_blocks_run", state, 2'b00);
    end
    step_req = 1'b1;
    e = cyc + 1;
    push_tick(e + 4, 1'b1, 2'b00);
    nxt();
    step_req = 1'b0;
    chk("cpu_halt_step_state", state, 2'b10);
    wait_until(e + 4);
    chk("cpu_halt_step_back", state, 2'b00);
    nxt();
    chk("cpu_halt_after_step", state, 2'b00);
    run = 1'b0; cpu_halt = 1'b0;

    // 6: run tick_count up to 0xFFFE, then wrap, then reset mid-run
    load_div(8'd0);
    run = 1'b1;
    e = cyc + 1;
    n = 32'h0000FFFE - int'(exp_tc);
    for (int k = 1; k <= n; k++) push_tick(e + k, 1'b0, 2'b01);
    wait_until(e + n);
    halt_req = 1'b1; run = 1'b0;
    nxt();
    halt_req = 1'b0;
    chk("preload_fffe", tick_count, 16'hFFFE);
    run = 1'b1;
    e = cyc + 1;
    for (int k = 1; k <= 3; k++) push_tick(e + k, 1'b0, 2'b01);
    wait_until(e + 3);
    chk("wrap_0001", tick_count, 16'h0001);
    reset = 1'b1; run = 1'b0;
    nxt();
    chk("rst_mid_state", state, 2'b00);
    chk("rst_mid_tick_en", tick_en, 1'b0);
    chk("rst_mid_ext_clk", ext_clk, 1'b0);
    chk("rst_mid_tick_count", tick_count, 16'd0);
    chk("rst_mid_step_done", step_done, 1'b0);
    reset = 1'b0;
    exp_ext = 1'b0; exp_tc = 16'd0;
    // Divisor must be back at its default of 3.
    run = 1'b1;
    e = cyc + 1;
    push_tick(e + 4, 1'b0, 2'b01);
    wait_until(e + 4);
    halt_req = 1'b1; run = 1'b0;
    nxt();
    halt_req = 1'b0;
    chk("post_rst_halted", state, 2'b00);

    repeat (3) nxt();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
